// File: rtl/wm8731_i2s_tx_if.sv
// Stereo sample-pair handshake between the voice mixer and the WM8731 transmitter.
interface wm8731_i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] in_left;
  logic [SAMPLE_WIDTH-1:0] in_right;
  logic                    in_valid;
  logic                    in_ready;

  modport master (output in_left, output in_right, output in_valid, input in_ready);
  modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/wm8731_i2s_tx.sv
// I2S / left-justified transmitter for the WM8731 DAC: pair FIFO, MCLK/BCLK dividers, frame sequencer.
// Pairs are popped only at frame start; pin changes happen on the CLOCK50M edge that drives BCLK low.
module wm8731_i2s_tx #(
  parameter int SAMPLE_WIDTH      = 16,
  parameter int SLOT_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int MCLK_HALF         = 2,
  parameter int BCLK_HALF         = 8,
  parameter int HOLD_ON_UNDERFLOW = 0
) (
  input  logic                        CLOCK50M,
  input  logic                        RESET_N,
  input  logic                        enable,
  input  logic                        mode_i2s,
  wm8731_i2s_tx_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow,
  input  logic                        clear_underflow,
  output logic                        MCLK,
  output logic                        BCLK,
  output logic                        DACLRC,
  output logic                        DACDAT
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(2 * SLOT_WIDTH);
  localparam int IW = $clog2(SAMPLE_WIDTH);
  localparam int MW = $clog2(MCLK_HALF + 1);
  localparam int BW = $clog2(BCLK_HALF + 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t          state;
  logic [MW-1:0]   mclk_cnt;
  logic [BW-1:0]   bclk_cnt;
  logic [CW-1:0]   bit_cnt;
  logic [CW-1:0]   next_cnt;
  logic            bclk_tick;
  logic            frame_start;
  logic            push;
  logic            pop;
  logic            mode_q;
  logic [SW-1:0]   cur_l, cur_r;
  logic [SW-1:0]   last_l, last_r;
  logic [SW-1:0]   load_l, load_r;
  logic [SW-1:0]   mem_l [FIFO_DEPTH];
  logic [SW-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // Serial bit for a frame position; I2S shifts the sample one BCLK later in each slot.
  function automatic logic slot_bit(input logic [CW-1:0] cnt, input logic i2s,
                                    input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [CW-1:0] pos;
    logic [SW-1:0] smp;
    logic [IW-1:0] idx;
    logic          b;
    b   = 1'b0;
    idx = '0;
    smp = (cnt >= CW'(SLOT_WIDTH)) ? r : l;
    pos = (cnt >= CW'(SLOT_WIDTH)) ? cnt - CW'(SLOT_WIDTH) : cnt;
    if (i2s) pos = pos - CW'(1);
    if (pos < CW'(SW)) begin
      idx = IW'(SW - 1) - IW'(pos);
      b   = smp[idx];
    end
    return b;
  endfunction

  assign bus.in_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign bclk_tick    = (bclk_cnt == BW'(BCLK_HALF - 1));
  assign next_cnt     = (bit_cnt == CW'(2 * SLOT_WIDTH - 1)) ? '0 : bit_cnt + CW'(1);
  assign frame_start  = bclk_tick && ((state == START) ||
                        (state == RUN && BCLK && next_cnt == '0 && enable));
  assign pop          = frame_start && (fifo_level != '0);
  assign load_l       = pop ? mem_l[rd_ptr] : ((HOLD_ON_UNDERFLOW != 0) ? last_l : '0);
  assign load_r       = pop ? mem_r[rd_ptr] : ((HOLD_ON_UNDERFLOW != 0) ? last_r : '0);

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      mclk_cnt <= '0;
      MCLK     <= 1'b0;
    end else if (mclk_cnt == MW'(MCLK_HALF - 1)) begin
      mclk_cnt <= '0;
      MCLK     <= ~MCLK;
    end else begin
      mclk_cnt <= mclk_cnt + MW'(1);
    end
  end

  always_ff @(posedge CLOCK50M) begin
    if (push) begin
      mem_l[wr_ptr] <= bus.in_left;
      mem_r[wr_ptr] <= bus.in_right;
    end
  end

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      bclk_cnt  <= '0;
      bit_cnt   <= '0;
      BCLK      <= 1'b0;
      DACLRC    <= 1'b0;
      DACDAT    <= 1'b0;
      mode_q    <= 1'b0;
      cur_l     <= '0;
      cur_r     <= '0;
      last_l    <= '0;
      last_r    <= '0;
      underflow <= 1'b0;
    end else begin
      if (clear_underflow) underflow <= 1'b0;
      if (frame_start) begin
        mode_q  <= mode_i2s;
        cur_l   <= load_l;
        cur_r   <= load_r;
        bit_cnt <= '0;
        DACLRC  <= 1'b0;
        DACDAT  <= slot_bit('0, mode_i2s, load_l, load_r);
        if (pop) begin
          last_l <= load_l;
          last_r <= load_r;
        end else begin
          underflow <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          BCLK     <= 1'b0;
          DACLRC   <= 1'b0;
          DACDAT   <= 1'b0;
          bclk_cnt <= '0;
          bit_cnt  <= '0;
          if (enable) state <= START;
        end
        START: begin
          bclk_cnt <= bclk_tick ? '0 : bclk_cnt + BW'(1);
          if (bclk_tick) state <= RUN;
        end
        RUN: begin
          bclk_cnt <= bclk_tick ? '0 : bclk_cnt + BW'(1);
          if (bclk_tick) begin
            BCLK <= ~BCLK;
            // Falling edge: advance the frame, or park at the boundary once enable has dropped.
            if (BCLK && !frame_start) begin
              if (next_cnt == '0) begin
                state   <= IDLE;
                DACLRC  <= 1'b0;
                DACDAT  <= 1'b0;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= next_cnt;
                DACLRC  <= (next_cnt >= CW'(SLOT_WIDTH));
                DACDAT  <= slot_bit(next_cnt, mode_q, cur_l, cur_r);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wm8731_i2s_tx.sv
// Bench for wm8731_i2s_tx: table vectors, random preload rounds and corner sequences, checked per captured frame.
module tb_wm8731_i2s_tx;
  localparam int BH = 8;
  localparam int MH = 2;

  logic CLOCK50M = 1'b0;
  always #5 CLOCK50M = ~CLOCK50M;

  logic        RESET_N, enable, mode_i2s, clear_underflow;
  logic        sel, drv_valid;
  logic [15:0] drv_l, drv_r;
  logic [2:0]  lvl0;
  logic [1:0]  lvl1;
  logic        uf0, uf1, mclk0, mclk1, bclk0, bclk1, lrc0, lrc1, dat0, dat1;
  logic        mb, ml, md, rdy, uf;
  logic [2:0]  lvl;

  wm8731_i2s_tx_if #(.SAMPLE_WIDTH(16)) bus0 ();
  wm8731_i2s_tx_if #(.SAMPLE_WIDTH(16)) bus1 ();
  assign bus0.in_left  = drv_l;
  assign bus0.in_right = drv_r;
  assign bus0.in_valid = drv_valid & ~sel;
  assign bus1.in_left  = drv_l;
  assign bus1.in_right = drv_r;
  assign bus1.in_valid = drv_valid & sel;

  wm8731_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(4), .MCLK_HALF(MH),
                  .BCLK_HALF(BH), .HOLD_ON_UNDERFLOW(0)) dut0 (
    .CLOCK50M(CLOCK50M), .RESET_N(RESET_N), .enable(enable & ~sel), .mode_i2s(mode_i2s),
    .bus(bus0), .fifo_level(lvl0), .underflow(uf0), .clear_underflow(clear_underflow),
    .MCLK(mclk0), .BCLK(bclk0), .DACLRC(lrc0), .DACDAT(dat0));

  wm8731_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(2), .MCLK_HALF(MH),
                  .BCLK_HALF(BH), .HOLD_ON_UNDERFLOW(1)) dut1 (
    .CLOCK50M(CLOCK50M), .RESET_N(RESET_N), .enable(enable & sel), .mode_i2s(mode_i2s),
    .bus(bus1), .fifo_level(lvl1), .underflow(uf1), .clear_underflow(clear_underflow),
    .MCLK(mclk1), .BCLK(bclk1), .DACLRC(lrc1), .DACDAT(dat1));

  assign mb  = sel ? bclk1 : bclk0;
  assign ml  = sel ? lrc1 : lrc0;
  assign md  = sel ? dat1 : dat0;
  assign rdy = sel ? bus1.in_ready : bus0.in_ready;
  assign uf  = sel ? uf1 : uf0;
  assign lvl = sel ? {1'b0, lvl1} : lvl0;

  int nchk = 0, nerr = 0;
  int bitn = 0, frames_done = 0, glitches = 0, since_rise = 0;
  logic [63:0] cap_d, cap_l, expf, last_frame;
  logic [63:0] exp_q [$];
  logic pb, pl, pd;

  typedef struct {
    logic        mode;
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] frame;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Expected serial frame: each slot is the sample followed by zeros, shifted one bit later for I2S.
  function automatic logic [63:0] model_frame(input logic i2s, input logic [15:0] l, input logic [15:0] r);
    logic [31:0] sl, sr;
    sl = {l, 16'h0000};
    sr = {r, 16'h0000};
    if (i2s) begin
      sl = sl >> 1;
      sr = sr >> 1;
    end
    return {sl, sr};
  endfunction

  // Pin monitor: captures DACLRC/DACDAT on each BCLK rise and checks whole frames.
  always @(negedge CLOCK50M) begin
    if (!RESET_N) begin
      bitn = 0; pb = 1'b0; pl = 1'b0; pd = 1'b0; since_rise = 0;
    end else begin
      since_rise++;
      if (mb && !pb) begin
        if (bitn > 0) chk("bclk_period", 64'(since_rise), 64'(2 * BH));
        since_rise = 0;
        cap_d = {cap_d[62:0], md};
        cap_l = {cap_l[62:0], ml};
        bitn++;
        if (bitn == 64) begin
          if (exp_q.size() > 0) begin
            expf = exp_q.pop_front();
            last_frame = expf;
          end else begin
            expf = sel ? last_frame : 64'h0;
          end
          chk("frame_dat", cap_d, expf);
          chk("frame_lrc", cap_l, 64'h00000000_FFFFFFFF);
          frames_done++;
          bitn = 0;
        end
      end
      if (mb && (ml !== pl || md !== pd)) glitches++;
      pb = mb; pl = ml; pd = md;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK50M);
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    int t;
    t = 0;
    drv_l = l; drv_r = r; drv_valid = 1'b1;
    while (!rdy && t < 5000) begin
      tick(1);
      t++;
    end
    if (!rdy) timeout("push");
    else tick(1);
    drv_valid = 1'b0;
  endtask

  task automatic start_round(input logic m);
    clear_underflow = 1'b1;
    tick(1);
    clear_underflow = 1'b0;
    frames_done = 0;
    mode_i2s = m;
    enable = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 1200 * (n + 1)) begin
      tick(1);
      t++;
    end
    if (frames_done < n) timeout("frames");
  endtask

  task automatic wait_bits(input int f, input int b);
    int t;
    t = 0;
    while (!(frames_done > f || (frames_done == f && bitn >= b)) && t < 3000) begin
      tick(1);
      t++;
    end
    if (t >= 3000) timeout("bits");
  endtask

  task automatic stop_round();
    enable = 1'b0;
    tick(3 * BH);
    chk("idle_bclk", 64'(mb), 64'(0));
    chk("idle_lrc", 64'(ml), 64'(0));
    chk("idle_dat", 64'(md), 64'(0));
    tick(4 * BH);
    chk("idle_nobits", 64'(bitn), 64'(0));
    chk("exp_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rl, rr;
    logic        rm;
    int          n, tog;
    logic        pm;

    tbl[0] = '{1'b0, 16'hFAFA, 16'h8F8F, 64'hFAFA0000_8F8F0000};
    tbl[1] = '{1'b1, 16'hFAFA, 16'h8F8F, 64'h7D7D0000_47C78000};
    tbl[2] = '{1'b0, 16'h0001, 16'h8000, 64'h00010000_80000000};
    tbl[3] = '{1'b1, 16'hFFFF, 16'h0001, 64'h7FFF8000_00008000};

    RESET_N = 1'b0; enable = 1'b0; mode_i2s = 1'b0; clear_underflow = 1'b0;
    sel = 1'b0; drv_valid = 1'b0; drv_l = '0; drv_r = '0; last_frame = '0;
    tick(3);
    chk("rst_mclk", 64'(mclk0), 64'(0));
    chk("rst_bclk", 64'(bclk0), 64'(0));
    chk("rst_lrc", 64'(lrc0), 64'(0));
    chk("rst_dat", 64'(dat0), 64'(0));
    chk("rst_uf", 64'(uf0), 64'(0));
    chk("rst_level", 64'(lvl0), 64'(0));
    chk("rst_ready", 64'(bus0.in_ready), 64'(1));
    RESET_N = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("mclk_div", 64'(mclk0), 64'((i / MH) % 2));
    end

    for (int i = 0; i < 4; i++) begin
      push_pair(tbl[i].l, tbl[i].r);
      exp_q.push_back(tbl[i].frame);
      chk("tbl_level1", 64'(lvl), 64'(1));
      start_round(tbl[i].mode);
      wait_frames(2);
      chk("tbl_uf", 64'(uf), 64'(1));
      chk("tbl_level0", 64'(lvl), 64'(0));
      stop_round();
    end

    start_round(1'b0);
    wait_bits(0, 2);
    chk("uf_set", 64'(uf), 64'(1));
    clear_underflow = 1'b1;
    tick(1);
    clear_underflow = 1'b0;
    chk("uf_clear", 64'(uf), 64'(0));
    wait_bits(1, 2);
    chk("uf_reset", 64'(uf), 64'(1));
    wait_frames(2);
    stop_round();

    for (int k = 0; k < 4; k++) begin
      rm = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        rl = 16'($urandom);
        rr = 16'($urandom);
        push_pair(rl, rr);
        exp_q.push_back(model_frame(rm, rl, rr));
      end
      chk("rnd_level", 64'(lvl), 64'(n));
      start_round(rm);
      wait_frames(n + 1);
      chk("rnd_uf", 64'(uf), 64'(1));
      stop_round();
    end

    for (int j = 0; j < 4; j++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      push_pair(rl, rr);
      exp_q.push_back(model_frame(1'b0, rl, rr));
    end
    chk("full_ready", 64'(rdy), 64'(0));
    chk("full_level", 64'(lvl), 64'(4));
    drv_l = 16'hC35A; drv_r = 16'h0FF0; drv_valid = 1'b1;
    exp_q.push_back(model_frame(1'b0, 16'hC35A, 16'h0FF0));
    tick(20);
    chk("full_hold_level", 64'(lvl), 64'(4));
    chk("full_hold_ready", 64'(rdy), 64'(0));
    start_round(1'b0);
    n = 0;
    while (!rdy && n < 200) begin
      tick(1);
      n++;
    end
    if (!rdy) timeout("refill");
    tick(1);
    drv_valid = 1'b0;
    chk("refill_level", 64'(lvl), 64'(4));
    wait_frames(6);
    stop_round();

    push_pair(16'hA5A5, 16'h5A5A);
    exp_q.push_back(model_frame(1'b1, 16'hA5A5, 16'h5A5A));
    start_round(1'b1);
    wait_bits(0, 10);
    enable = 1'b0;
    wait_frames(1);
    stop_round();
    chk("drop_frames", 64'(frames_done), 64'(1));
    chk("drop_uf", 64'(uf), 64'(0));

    push_pair(16'h1111, 16'h2222);
    push_pair(16'h3333, 16'h4444);
    start_round(1'b0);
    wait_bits(0, 40);
    chk("mid_level", 64'(lvl), 64'(1));
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_mclk", 64'(mclk0), 64'(0));
    chk("arst_bclk", 64'(bclk0), 64'(0));
    chk("arst_lrc", 64'(lrc0), 64'(0));
    chk("arst_dat", 64'(dat0), 64'(0));
    chk("arst_level", 64'(lvl0), 64'(0));
    enable = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tog = 0;
    pm = mclk0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (mclk0 !== pm) tog++;
      pm = mclk0;
    end
    chk("mclk_resume", 64'(tog), 64'(8 / MH));
    chk("post_rst_level", 64'(lvl0), 64'(0));

    sel = 1'b1;
    last_frame = '0;
    tick(2);
    push_pair(16'h1234, 16'h5678);
    exp_q.push_back(model_frame(1'b0, 16'h1234, 16'h5678));
    start_round(1'b0);
    wait_frames(3);
    chk("hold_uf", 64'(uf), 64'(1));
    stop_round();
    chk("hold_last", last_frame, 64'h12340000_56780000);

    chk("glitches", 64'(glitches), 64'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
